puf_response_stabilizer: RTL and testbench

//  Upstream of the PUF response-to-number converter. Collects NUM_SAMPLES raw

---
 rtl/puf_response_stabilizer_if.sv | 23 ++
 rtl/puf_response_stabilizer.sv | 134 +++++++++++++
 tb/tb_puf_response_stabilizer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/puf_response_stabilizer_if.sv
// Handshake bundle between the PUF sample source / consumer and the response stabilizer.
interface puf_response_stabilizer_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] raw_response;
   logic             raw_valid;
   logic             busy;
   logic [WIDTH-1:0] puf_response;
   logic             response_valid;
   logic             timeout_err;
   logic [WIDTH-1:0] unstable_mask;

   modport master (
      output start, raw_response, raw_valid,
      input  busy, puf_response, response_valid, timeout_err, unstable_mask
   );

   modport slave (
      input  start, raw_response, raw_valid,
      output busy, puf_response, response_valid, timeout_err, unstable_mask
   );
endinterface

// File: rtl/puf_response_stabilizer.sv
// Temporal majority voter: collects NUM_SAMPLES raw PUF evaluations and emits one voted response.
// Define PUF_STABILITY_FLAG_EN to build the per-bit non-unanimous flag logic driving unstable_mask.
module puf_response_stabilizer #(
   parameter int unsigned WIDTH          = 16,
   parameter int unsigned NUM_SAMPLES    = 7,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                        clk,
   input  logic                        rst,
   puf_response_stabilizer_if.slave    bus
);
   localparam int unsigned CW = $clog2(NUM_SAMPLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST_SAMPLE = CW'(NUM_SAMPLES - 1);
   localparam logic [CW-1:0] HALF        = CW'(NUM_SAMPLES / 2);
   localparam logic [TW-1:0] LAST_GAP    = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      RESOLVE = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [WIDTH-1:0][CW-1:0] ones_q, ones_d;
   logic [CW-1:0]            sample_cnt_q, sample_cnt_d;
   logic [TW-1:0]            tmo_cnt_q, tmo_cnt_d;
   logic [WIDTH-1:0]         puf_response_q, puf_response_d;
   logic                     response_valid_q, response_valid_d;
   logic                     timeout_err_q, timeout_err_d;
`ifdef PUF_STABILITY_FLAG_EN
   logic [WIDTH-1:0]         unstable_mask_q, unstable_mask_d;
   localparam logic [CW-1:0] ALL_ONES_CNT = CW'(NUM_SAMPLES);
`endif

   always_comb begin
      state_d          = state_q;
      ones_d           = ones_q;
      sample_cnt_d     = sample_cnt_q;
      tmo_cnt_d        = tmo_cnt_q;
      puf_response_d   = puf_response_q;
      response_valid_d = 1'b0;
      timeout_err_d    = 1'b0;
`ifdef PUF_STABILITY_FLAG_EN
      unstable_mask_d  = unstable_mask_q;
`endif

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               ones_d       = '0;
               sample_cnt_d = '0;
               tmo_cnt_d    = '0;
               state_d      = COLLECT;
            end
         end

         COLLECT: begin
            if (bus.raw_valid) begin
               for (int unsigned i = 0; i < WIDTH; i++) begin
                  ones_d[i] = ones_q[i] + CW'(bus.raw_response[i]);
               end
               sample_cnt_d = sample_cnt_q + 1'b1;
               tmo_cnt_d    = '0;
               if (sample_cnt_q == LAST_SAMPLE) begin
                  state_d = RESOLVE;
               end
            end else if (tmo_cnt_q == LAST_GAP) begin
               // This gap makes the idle count reach TIMEOUT_CYCLES: abort, keep last result.
               timeout_err_d = 1'b1;
               tmo_cnt_d     = '0;
               state_d       = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end

         RESOLVE: begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
               puf_response_d[i] = (ones_q[i] > HALF);
`ifdef PUF_STABILITY_FLAG_EN
               unstable_mask_d[i] = (ones_q[i] != '0) && (ones_q[i] != ALL_ONES_CNT);
`endif
            end
            response_valid_d = 1'b1;
            state_d          = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         ones_q           <= '0;
         sample_cnt_q     <= '0;
         tmo_cnt_q        <= '0;
         puf_response_q   <= '0;
         response_valid_q <= 1'b0;
         timeout_err_q    <= 1'b0;
      end else begin
         state_q          <= state_d;
         ones_q           <= ones_d;
         sample_cnt_q     <= sample_cnt_d;
         tmo_cnt_q        <= tmo_cnt_d;
         puf_response_q   <= puf_response_d;
         response_valid_q <= response_valid_d;
         timeout_err_q    <= timeout_err_d;
      end
   end

`ifdef PUF_STABILITY_FLAG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         unstable_mask_q <= '0;
      end else begin
         unstable_mask_q <= unstable_mask_d;
      end
   end

   assign bus.unstable_mask = unstable_mask_q;
`else
   assign bus.unstable_mask = '0;
`endif

   assign bus.busy           = (state_q != IDLE);
   assign bus.puf_response   = puf_response_q;
   assign bus.response_valid = response_valid_q;
   assign bus.timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_puf_response_stabilizer.sv
// Directed self-checking bench for puf_response_stabilizer (WIDTH=16, NUM_SAMPLES=7, TIMEOUT_CYCLES=255).
module tb_puf_response_stabilizer;
   logic clk = 1'b0;
   logic rst;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned rv_cnt   = 0;
   int unsigned te_cnt   = 0;
   int unsigned rv_base;
   int unsigned te_base;

`ifdef PUF_STABILITY_FLAG_EN
   localparam logic [15:0] MASK_ALL = 16'hFFFF;
`else
   localparam logic [15:0] MASK_ALL = 16'h0000;
`endif

   puf_response_stabilizer_if #(.WIDTH(16)) bus ();

   puf_response_stabilizer #(
      .WIDTH          (16),
      .NUM_SAMPLES    (7),
      .TIMEOUT_CYCLES (255)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.response_valid === 1'b1) rv_cnt++;
      if (bus.timeout_err === 1'b1)    te_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic send(input logic [15:0] val);
      bus.raw_response = val;
      bus.raw_valid    = 1'b1;
      tick();
      bus.raw_valid    = 1'b0;
   endtask

   logic [15:0] t5_val [7] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h0000, 16'h0000, 16'h7FFE};
   int unsigned t5_gap [7] = '{0, 2, 1, 3, 0, 1, 2};

   initial begin
      rst              = 1'b1;
      bus.start        = 1'b0;
      bus.raw_valid    = 1'b0;
      bus.raw_response = '0;
      tick();
      tick();
      check("reset_busy",  32'(bus.busy),           32'd0);
      check("reset_valid", 32'(bus.response_valid), 32'd0);
      check("reset_tmo",   32'(bus.timeout_err),    32'd0);
      check("reset_resp",  32'(bus.puf_response),   32'h0);
      check("reset_mask",  32'(bus.unstable_mask),  32'h0);
      rst = 1'b0;
      tick();

      // 1: unanimous ones, back-to-back samples
      do_start();
      check("t1_busy_collect", 32'(bus.busy), 32'd1);
      for (int k = 0; k < 7; k++) send(16'hFFFF);
      check("t1_resolve_busy",  32'(bus.busy),           32'd1);
      check("t1_resolve_valid", 32'(bus.response_valid), 32'd0);
      tick();
      check("t1_valid", 32'(bus.response_valid), 32'd1);
      check("t1_resp",  32'(bus.puf_response),   32'hFFFF);
      check("t1_mask",  32'(bus.unstable_mask),  32'h0);
      check("t1_idle",  32'(bus.busy),           32'd0);
      tick();
      check("t1_strobe_1cyc", 32'(bus.response_valid), 32'd0);
      check("t1_hold",        32'(bus.puf_response),   32'hFFFF);

      // 2: 4 vs 3 split on every bit
      do_start();
      for (int k = 0; k < 4; k++) send(16'hA5A5);
      for (int k = 0; k < 3; k++) send(16'h5A5A);
      tick();
      check("t2_valid", 32'(bus.response_valid), 32'd1);
      check("t2_resp",  32'(bus.puf_response),   32'hA5A5);
      check("t2_mask",  32'(bus.unstable_mask),  32'(MASK_ALL));
      tick();

      // 3: timeout after exactly 255 idle cycles
      rv_base = rv_cnt;
      te_base = te_cnt;
      do_start();
      for (int k = 0; k < 3; k++) send(16'h0F0F);
      repeat (254) tick();
      check("t3_busy_at_254", 32'(bus.busy),        32'd1);
      check("t3_tmo_at_254",  32'(bus.timeout_err), 32'd0);
      tick();
      check("t3_tmo",       32'(bus.timeout_err),  32'd1);
      check("t3_busy",      32'(bus.busy),         32'd0);
      check("t3_resp_kept", 32'(bus.puf_response), 32'hA5A5);
      check("t3_mask_kept", 32'(bus.unstable_mask), 32'(MASK_ALL));
      tick();
      check("t3_tmo_1cyc",  32'(bus.timeout_err), 32'd0);
      check("t3_tmo_count", te_cnt - te_base, 32'd1);
      check("t3_no_valid",  rv_cnt - rv_base, 32'd0);

      // 4: reset mid-collection, no stale votes afterwards
      rv_base = rv_cnt;
      te_base = te_cnt;
      do_start();
      for (int k = 0; k < 5; k++) send(16'hFFFF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t4_rst_busy", 32'(bus.busy),          32'd0);
      check("t4_rst_resp", 32'(bus.puf_response),  32'h0);
      check("t4_rst_mask", 32'(bus.unstable_mask), 32'h0);
      do_start();
      for (int k = 0; k < 7; k++) send(16'h1234);
      tick();
      check("t4_valid", 32'(bus.response_valid), 32'd1);
      check("t4_resp",  32'(bus.puf_response),   32'h1234);
      check("t4_mask",  32'(bus.unstable_mask),  32'h0);
      check("t4_pulses", (rv_cnt - rv_base) + (te_cnt - te_base), 32'd0);
      tick();

      // 5: gapped samples with a stray start pulse mid-collection
      rv_base = rv_cnt;
      do_start();
      for (int k = 0; k < 7; k++) begin
         for (int g = 0; g < int'(t5_gap[k]); g++) begin
            if (k == 3 && g == 0) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
         end
         send(t5_val[k]);
      end
      check("t5_resolve_busy", 32'(bus.busy), 32'd1);
      tick();
      check("t5_valid", 32'(bus.response_valid), 32'd1);
      check("t5_resp",  32'(bus.puf_response),   32'h8001);
      check("t5_mask",  32'(bus.unstable_mask),  32'(MASK_ALL));

      // 6: start coincident with response_valid
      do_start();
      check("t6_busy",      32'(bus.busy),           32'd1);
      check("t6_valid_off", 32'(bus.response_valid), 32'd0);
      check("t5_one_valid", rv_cnt - rv_base,        32'd1);
      for (int k = 0; k < 7; k++) send(16'h0000);
      tick();
      check("t6_valid", 32'(bus.response_valid), 32'd1);
      check("t6_resp",  32'(bus.puf_response),   32'h0000);
      check("t6_mask",  32'(bus.unstable_mask),  32'h0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
